// File: rtl/osd_mam_wb_if_if.sv
// Port bundles for osd_mam_wb_if: the upstream MAM memory port and the
// Wishbone B3 master bus it drives.
interface mam_mem_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32
);
    logic                    req_valid;
    logic                    req_ready;
    logic                    req_rw;
    logic [ADDR_WIDTH-1:0]   req_addr;
    logic                    req_burst;
    logic [13:0]             req_beats;
    logic                    write_valid;
    logic [DATA_WIDTH-1:0]   write_data;
    logic [DATA_WIDTH/8-1:0] write_strb;
    logic                    write_ready;
    logic                    read_valid;
    logic [DATA_WIDTH-1:0]   read_data;
    logic                    read_ready;

    modport master (
        output req_valid, req_rw, req_addr, req_burst, req_beats,
               write_valid, write_data, write_strb, read_ready,
        input  req_ready, write_ready, read_valid, read_data
    );

    modport slave (
        input  req_valid, req_rw, req_addr, req_burst, req_beats,
               write_valid, write_data, write_strb, read_ready,
        output req_ready, write_ready, read_valid, read_data
    );
endinterface

interface wb_bus_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32
);
    logic                    wb_cyc_o;
    logic                    wb_stb_o;
    logic                    wb_we_o;
    logic [ADDR_WIDTH-1:0]   wb_adr_o;
    logic [DATA_WIDTH-1:0]   wb_dat_o;
    logic [DATA_WIDTH/8-1:0] wb_sel_o;
    logic [2:0]              wb_cti_o;
    logic [1:0]              wb_bte_o;
    logic                    wb_ack_i;
    logic                    wb_err_i;
    logic [DATA_WIDTH-1:0]   wb_dat_i;

    modport master (
        output wb_cyc_o, wb_stb_o, wb_we_o, wb_adr_o, wb_dat_o,
               wb_sel_o, wb_cti_o, wb_bte_o,
        input  wb_ack_i, wb_err_i, wb_dat_i
    );

    modport slave (
        input  wb_cyc_o, wb_stb_o, wb_we_o, wb_adr_o, wb_dat_o,
               wb_sel_o, wb_cti_o, wb_bte_o,
        output wb_ack_i, wb_err_i, wb_dat_i
    );
endinterface

// File: rtl/osd_mam_wb_if.sv
// Turns MAM memory beats into Wishbone B3 registered-feedback master transfers.
// Bursts keep CYC asserted across all beats; one write and one read word are buffered.
module osd_mam_wb_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32
) (
    input  logic     clk,
    input  logic     rst,
    mam_mem_if.slave mem,
    wb_bus_if.master wb,
    output logic     bus_err
);
    localparam int SEL_WIDTH = DATA_WIDTH / 8;
    localparam logic [ADDR_WIDTH-1:0] ADR_STEP = ADDR_WIDTH'(SEL_WIDTH);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        WDATA = 3'd1,
        WBUS  = 3'd2,
        RBUS  = 3'd3,
        RHOLD = 3'd4
    } state_t;

    state_t                state_r;
    state_t                state_nxt_s;
    logic [13:0]           beats_left_r;
    logic [ADDR_WIDTH-1:0] adr_r;
    logic                  we_r;
    logic                  burst_r;
    logic                  cyc_r;
    logic                  stb_r;
    logic                  bus_err_r;
    logic [DATA_WIDTH-1:0] wbuf_r;
    logic [DATA_WIDTH-1:0] rbuf_r;
    logic [SEL_WIDTH-1:0]  sel_r;

    logic req_acc_s;
    logic wr_acc_s;
    logic bus_done_s;
    logic advance_s;
    logic bus_resp_s;
    logic last_beat_s;

    // ack and err both terminate a beat; they only matter in states that drive STB
    assign bus_resp_s  = wb.wb_ack_i | wb.wb_err_i;
    assign last_beat_s = (beats_left_r == 14'd1);

    // Next-state decode and handshake strobes
    always_comb begin
        state_nxt_s = state_r;
        req_acc_s   = 1'b0;
        wr_acc_s    = 1'b0;
        bus_done_s  = 1'b0;
        advance_s   = 1'b0;
        case (state_r)
            IDLE: begin
                if (mem.req_valid) begin
                    req_acc_s   = 1'b1;
                    state_nxt_s = mem.req_rw ? WDATA : RBUS;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            WDATA: begin
                if (mem.write_valid) begin
                    wr_acc_s    = 1'b1;
                    state_nxt_s = WBUS;
                end else begin
                    state_nxt_s = WDATA;
                end
            end
            WBUS: begin
                if (bus_resp_s) begin
                    bus_done_s  = 1'b1;
                    advance_s   = 1'b1;
                    state_nxt_s = last_beat_s ? IDLE : WDATA;
                end else begin
                    state_nxt_s = WBUS;
                end
            end
            RBUS: begin
                if (bus_resp_s) begin
                    bus_done_s  = 1'b1;
                    state_nxt_s = RHOLD;
                end else begin
                    state_nxt_s = RBUS;
                end
            end
            RHOLD: begin
                if (mem.read_ready) begin
                    advance_s   = 1'b1;
                    state_nxt_s = last_beat_s ? IDLE : RBUS;
                end else begin
                    state_nxt_s = RHOLD;
                end
            end
            default: begin
                state_nxt_s = IDLE;
            end
        endcase
    end

    // State, bus control and data buffer registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r      <= IDLE;
            beats_left_r <= 14'd0;
            adr_r        <= '0;
            we_r         <= 1'b0;
            burst_r      <= 1'b0;
            cyc_r        <= 1'b0;
            stb_r        <= 1'b0;
            bus_err_r    <= 1'b0;
            wbuf_r       <= '0;
            rbuf_r       <= '0;
            sel_r        <= '0;
        end else begin
            state_r <= state_nxt_s;
            stb_r   <= (state_nxt_s == WBUS) || (state_nxt_s == RBUS);
            // CYC rises with the first STB and only falls when the transfer ends
            case (state_nxt_s)
                IDLE:       cyc_r <= 1'b0;
                WBUS, RBUS: cyc_r <= 1'b1;
                default:    cyc_r <= cyc_r;
            endcase
            if (req_acc_s) begin
                adr_r        <= mem.req_addr;
                we_r         <= mem.req_rw;
                burst_r      <= mem.req_burst;
                beats_left_r <= (mem.req_beats == 14'd0) ? 14'd1 : mem.req_beats;
                sel_r        <= '1;
                bus_err_r    <= 1'b0;
            end
            if (wr_acc_s) begin
                wbuf_r <= mem.write_data;
                sel_r  <= burst_r ? {SEL_WIDTH{1'b1}} : mem.write_strb;
            end
            if (bus_done_s) begin
                if (wb.wb_err_i) begin
                    bus_err_r <= 1'b1;
                end
                if (!we_r) begin
                    rbuf_r <= wb.wb_dat_i;
                end
            end
            if (advance_s) begin
                beats_left_r <= beats_left_r - 14'd1;
                if (!last_beat_s) begin
                    adr_r <= adr_r + ADR_STEP;
                end
            end
        end
    end

    assign mem.req_ready   = (state_r == IDLE) && !rst;
    assign mem.write_ready = (state_r == WDATA);
    assign mem.read_valid  = (state_r == RHOLD);
    assign mem.read_data   = rbuf_r;

    assign wb.wb_cyc_o = cyc_r;
    assign wb.wb_stb_o = stb_r;
    assign wb.wb_we_o  = we_r;
    assign wb.wb_adr_o = adr_r;
    assign wb.wb_dat_o = wbuf_r;
    assign wb.wb_sel_o = sel_r;
    assign wb.wb_cti_o = !burst_r ? 3'b000 : ((beats_left_r > 14'd1) ? 3'b010 : 3'b111);
    assign wb.wb_bte_o = 2'b00;

    assign bus_err = bus_err_r;
endmodule
